// File: rtl/veririsc_sequencer.sv
// VeriRisc eight-phase instruction sequencer: steps fetch/decode/execute phases
// and decodes the load, memory and bus strobes from (phase, opcode, zero, halted).
module veririsc_sequencer #(
  parameter int OpWidth = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OpWidth-1:0] opcode,
  input  logic               zero,
  output logic [2:0]         phase,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               halt,
  output logic               inc_pc,
  output logic               ld_ac,
  output logic               ld_pc,
  output logic               wr,
  output logic               data_e
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [OpWidth-1:0] OP_HLT = OpWidth'(0);
  localparam logic [OpWidth-1:0] OP_SKZ = OpWidth'(1);
  localparam logic [OpWidth-1:0] OP_ADD = OpWidth'(2);
  localparam logic [OpWidth-1:0] OP_AND = OpWidth'(3);
  localparam logic [OpWidth-1:0] OP_XOR = OpWidth'(4);
  localparam logic [OpWidth-1:0] OP_LDA = OpWidth'(5);
  localparam logic [OpWidth-1:0] OP_STO = OpWidth'(6);
  localparam logic [OpWidth-1:0] OP_JMP = OpWidth'(7);

  phase_t state;
  phase_t state_nxt;
  logic   halted;
  logic   halted_nxt;
  logic   alu_op;

  assign phase  = state;
  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= halted_nxt;
    end
  end

  // A HLT seen in OP_ADDR parks the counter there; only reset releases it.
  always_comb begin
    state_nxt  = state;
    halted_nxt = halted;
    if (!halted) begin
      if (state == OP_ADDR && opcode == OP_HLT) begin
        halted_nxt = 1'b1;
      end else begin
        state_nxt = phase_t'(state + 3'd1);
      end
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (state)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_veririsc_sequencer.sv
// Bench for veririsc_sequencer: table of per-phase expectations per opcode, plus
// hand-written halt and asynchronous-reset sequences, checked through a scoreboard queue.
module tb_veririsc_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
  logic [8:0] outs;

  // Strobe order: sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e
  localparam logic [8:0] P0   = 9'b100000000;
  localparam logic [8:0] P1   = 9'b110000000;
  localparam logic [8:0] P23  = 9'b111000000;
  localparam logic [8:0] P4   = 9'b000010000;
  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] RD   = 9'b010000000;
  localparam logic [8:0] RDAC = 9'b010001000;
  localparam logic [8:0] DE   = 9'b000000001;
  localparam logic [8:0] WRDE = 9'b000000011;
  localparam logic [8:0] INC  = 9'b000010000;
  localparam logic [8:0] LDPC = 9'b000000100;
  localparam logic [8:0] H4   = 9'b000110000;
  localparam logic [8:0] HALT = 9'b000100000;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [2:0] ph;
    logic [8:0] outs;
  } vec_t;

  typedef struct {
    logic [2:0] ph;
    logic [8:0] outs;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  veririsc_sequencer #(.OpWidth(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .phase(phase),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
    .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e)
  );

  assign outs = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addGroup(input logic [2:0] op, input logic z,
                          input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] e[8];
    e = '{P0, P1, P23, P23, P4, e5, e6, e7};
    for (int p = 0; p < 8; p++) vecs.push_back('{op, z, 3'(p), e[p]});
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard-empty got=none want=entry");
      return;
    end
    e = sb.pop_front();
    total++;
    if (phase !== e.ph || outs !== e.outs) begin
      bad++;
      $display("[TB] FAIL %s got phase=%0d strobes=%b want phase=%0d strobes=%b",
               e.tag, phase, outs, e.ph, e.outs);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic z, input logic [2:0] eph,
                               input logic [8:0] eouts, input string tag);
    opcode = op;
    zero   = z;
    sb.push_back('{eph, eouts, tag});
    #1;
    checkOutput();
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    addGroup(LDA, 1'b0, RD, RD, RDAC);
    addGroup(STO, 1'b0, NONE, DE, WRDE);
    addGroup(SKZ, 1'b1, NONE, INC, NONE);
    addGroup(SKZ, 1'b0, NONE, NONE, NONE);
    addGroup(JMP, 1'b1, NONE, LDPC, LDPC);

    rst    = 1'b0;
    opcode = LDA;
    zero   = 1'b0;
    #2;
    applyStimulus(LDA, 1'b0, 3'd0, P0, "reset");
    @(posedge clk);
    #1;
    applyStimulus(STO, 1'b1, 3'd0, P0, "reset-held");
    @(negedge clk);
    rst = 1'b1;

    // Opcode and zero are randomised in phases 0-3 where they must not matter.
    foreach (vecs[i]) begin
      if (vecs[i].ph < 3'd4)
        applyStimulus(3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
                      vecs[i].ph, vecs[i].outs, "vector");
      else
        applyStimulus(vecs[i].op, vecs[i].z, vecs[i].ph, vecs[i].outs, "vector");
      step();
    end

    applyStimulus(HLT, 1'b0, 3'd0, P0, "hlt-p0");
    step();
    applyStimulus(HLT, 1'b0, 3'd1, P1, "hlt-p1");
    step();
    applyStimulus(HLT, 1'b0, 3'd2, P23, "hlt-p2");
    step();
    applyStimulus(HLT, 1'b0, 3'd3, P23, "hlt-p3");
    step();
    applyStimulus(HLT, 1'b0, 3'd4, H4, "hlt-p4");
    for (int i = 0; i < 20; i++) begin
      step();
      applyStimulus(3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), 3'd4, HALT, "halted");
    end

    #1;
    rst = 1'b0;
    applyStimulus(LDA, 1'b0, 3'd0, P0, "halt-async-reset");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(JMP, 1'b0, 3'd0, P0, "resume-p0");
    step();
    applyStimulus(JMP, 1'b0, 3'd1, P1, "resume-p1");
    step();
    applyStimulus(JMP, 1'b0, 3'd2, P23, "jmp-p2");
    step();
    applyStimulus(JMP, 1'b0, 3'd3, P23, "jmp-p3");
    step();
    applyStimulus(JMP, 1'b0, 3'd4, P4, "jmp-p4");
    step();
    applyStimulus(JMP, 1'b0, 3'd5, NONE, "jmp-p5");
    step();
    applyStimulus(JMP, 1'b0, 3'd6, LDPC, "jmp-p6");

    #1;
    rst = 1'b0;
    applyStimulus(JMP, 1'b0, 3'd0, P0, "mid-reset");
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < 8; p++) begin
      logic [8:0] e[8];
      e = '{P0, P1, P23, P23, P4, RD, RD, RDAC};
      applyStimulus(LDA, 1'b0, 3'(p), e[p], "after-mid-reset");
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
